// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the draw pipeline stages.
package vga_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;
  localparam int RGB_W  = 12;

  localparam logic [RGB_W-1:0] RGB_BLACK      = 12'h000;
  localparam logic [RGB_W-1:0] RGB_TANK_GREEN = 12'h080;

  // Movement sequencer: idle until a frame tick, then one cycle per axis.
  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    STEP_X     = 2'd1,
    STEP_Y     = 2'd2
  } move_state_t;

endpackage

// File: rtl/tank_move_fsm.sv
// Per-frame tank movement: detects the vblank rising edge, samples the
// direction inputs on that tick, then updates x and y (one cycle each)
// with clamping so the rectangle always stays inside the visible area.
module tank_move_fsm
  import vga_pkg::*;
#(
  parameter int RECT_W = 32,
  parameter int RECT_H = 32,
  parameter int STEP   = 2,
  parameter int X_INIT = 496,
  parameter int Y_INIT = 368
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblnk_in,
  input  logic              dir_up,
  input  logic              dir_down,
  input  logic              dir_left,
  input  logic              dir_right,
  output logic [HCNT_W-1:0] xpos,
  output logic [VCNT_W-1:0] ypos
);

  // One extra bit so underflow/overflow show up instead of wrapping.
  localparam int XW = HCNT_W + 1;
  localparam int YW = VCNT_W + 1;

  localparam logic [XW-1:0] X_MAX    = XW'(H_ACTIVE - RECT_W);
  localparam logic [YW-1:0] Y_MAX    = YW'(V_ACTIVE - RECT_H);
  localparam logic [XW-1:0] X_STRIDE = XW'(STEP);
  localparam logic [YW-1:0] Y_STRIDE = YW'(STEP);

  move_state_t state;

  logic vblnk_q;
  logic armed;
  logic frame_tick;

  logic up_q, down_q, left_q, right_q;

  logic [XW-1:0]     x_ext, x_dec, x_inc;
  logic [YW-1:0]     y_ext, y_dec, y_inc;
  logic [HCNT_W-1:0] x_next;
  logic [VCNT_W-1:0] y_next;

  // 'armed' blocks a tick until vblank has been seen low after reset,
  // so a vblank already high at release is not mistaken for an edge.
  assign frame_tick = vblnk_in & ~vblnk_q & armed;

  // Vblank edge detector state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      vblnk_q <= vblnk_in;
      armed   <= armed | ~vblnk_in;
    end
  end

  // Clamped candidate positions from the sampled directions.
  always_comb begin
    x_ext  = {1'b0, xpos};
    y_ext  = {1'b0, ypos};
    x_dec  = x_ext - X_STRIDE;
    x_inc  = x_ext + X_STRIDE;
    y_dec  = y_ext - Y_STRIDE;
    y_inc  = y_ext + Y_STRIDE;
    x_next = xpos;
    y_next = ypos;
    if (left_q && !right_q) begin
      x_next = x_dec[XW-1] ? '0 : x_dec[HCNT_W-1:0];
    end else if (right_q && !left_q) begin
      x_next = (x_inc > X_MAX) ? X_MAX[HCNT_W-1:0] : x_inc[HCNT_W-1:0];
    end
    if (up_q && !down_q) begin
      y_next = y_dec[YW-1] ? '0 : y_dec[VCNT_W-1:0];
    end else if (down_q && !up_q) begin
      y_next = (y_inc > Y_MAX) ? Y_MAX[VCNT_W-1:0] : y_inc[VCNT_W-1:0];
    end
  end

  // Movement sequencer with direction sampling and position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_FRAME;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      xpos    <= HCNT_W'(X_INIT);
      ypos    <= VCNT_W'(Y_INIT);
    end else begin
      case (state)
        WAIT_FRAME: begin
          if (frame_tick) begin
            up_q    <= dir_up;
            down_q  <= dir_down;
            left_q  <= dir_left;
            right_q <= dir_right;
            state   <= STEP_X;
          end
        end
        STEP_X: begin
          xpos  <= x_next;
          state <= STEP_Y;
        end
        STEP_Y: begin
          ypos  <= y_next;
          state <= WAIT_FRAME;
        end
        default: state <= WAIT_FRAME;
      endcase
    end
  end

endmodule

// File: rtl/draw_tank.sv
// Overlays a solid tank rectangle onto the background pixel stream and
// re-emits the timing bus delayed by the same two cycles as the RGB path.
module draw_tank
  import vga_pkg::*;
#(
  parameter int               RECT_W = 32,
  parameter int               RECT_H = 32,
  parameter int               STEP   = 2,
  parameter logic [RGB_W-1:0] COLOR  = RGB_TANK_GREEN,
  parameter int               X_INIT = 496,
  parameter int               Y_INIT = 368
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HCNT_W-1:0] hcount_in,
  input  logic [VCNT_W-1:0] vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [RGB_W-1:0]  rgb_in,
  input  logic              dir_up,
  input  logic              dir_down,
  input  logic              dir_left,
  input  logic              dir_right,
  output logic [HCNT_W-1:0] hcount_out,
  output logic [VCNT_W-1:0] vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [RGB_W-1:0]  rgb_out,
  output logic [HCNT_W-1:0] xpos_out,
  output logic [VCNT_W-1:0] ypos_out
);

  localparam int XW = HCNT_W + 1;
  localparam int YW = VCNT_W + 1;

  logic [HCNT_W-1:0] hcount_s1;
  logic [VCNT_W-1:0] vcount_s1;
  logic              hsync_s1, vsync_s1, hblnk_s1, vblnk_s1;
  logic [RGB_W-1:0]  rgb_s1;
  logic              hit_s1;

  logic [XW-1:0] h_ext, x_lo, x_hi;
  logic [YW-1:0] v_ext, y_lo, y_hi;
  logic          hit;

  tank_move_fsm #(
    .RECT_W (RECT_W),
    .RECT_H (RECT_H),
    .STEP   (STEP),
    .X_INIT (X_INIT),
    .Y_INIT (Y_INIT)
  ) u_move (
    .clk       (clk),
    .rst_n     (rst_n),
    .vblnk_in  (vblnk_in),
    .dir_up    (dir_up),
    .dir_down  (dir_down),
    .dir_left  (dir_left),
    .dir_right (dir_right),
    .xpos      (xpos_out),
    .ypos      (ypos_out)
  );

  // Rectangle hit test at extended width so x+RECT_W cannot wrap.
  always_comb begin
    h_ext = {1'b0, hcount_in};
    v_ext = {1'b0, vcount_in};
    x_lo  = {1'b0, xpos_out};
    y_lo  = {1'b0, ypos_out};
    x_hi  = x_lo + XW'(RECT_W);
    y_hi  = y_lo + YW'(RECT_H);
    hit   = !hblnk_in && !vblnk_in &&
            (h_ext >= x_lo) && (h_ext < x_hi) &&
            (v_ext >= y_lo) && (v_ext < y_hi);
  end

  // Stage 1: register the timing bus, background pixel and hit flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_s1 <= '0;
      vcount_s1 <= '0;
      hsync_s1  <= 1'b0;
      vsync_s1  <= 1'b0;
      hblnk_s1  <= 1'b0;
      vblnk_s1  <= 1'b0;
      rgb_s1    <= '0;
      hit_s1    <= 1'b0;
    end else begin
      hcount_s1 <= hcount_in;
      vcount_s1 <= vcount_in;
      hsync_s1  <= hsync_in;
      vsync_s1  <= vsync_in;
      hblnk_s1  <= hblnk_in;
      vblnk_s1  <= vblnk_in;
      rgb_s1    <= rgb_in;
      hit_s1    <= hit;
    end
  end

  // Stage 2: output registers with blanking/tank/background selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= RGB_BLACK;
    end else begin
      hcount_out <= hcount_s1;
      vcount_out <= vcount_s1;
      hsync_out  <= hsync_s1;
      vsync_out  <= vsync_s1;
      hblnk_out  <= hblnk_s1;
      vblnk_out  <= vblnk_s1;
      if (hblnk_s1 || vblnk_s1) begin
        rgb_out <= RGB_BLACK;
      end else if (hit_s1) begin
        rgb_out <= COLOR;
      end else begin
        rgb_out <= rgb_s1;
      end
    end
  end

endmodule

// File: tb/tb_draw_tank.sv
// Self-checking bench for draw_tank: pixel alignment, per-frame movement,
// clamping, direction sampling and asynchronous reset.
module tb_draw_tank;

  localparam int          RW   = 32;
  localparam int          RH   = 32;
  localparam int          MV   = 2;
  localparam logic [11:0] TANK = 12'h080;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        dir_up, dir_down, dir_left, dir_right;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [10:0] xpos_out;
  logic [9:0]  ypos_out;

  int tests = 0;
  int fails = 0;
  int mx = 496;
  int my = 368;

  draw_tank #(
    .RECT_W (RW),
    .RECT_H (RH),
    .STEP   (MV),
    .COLOR  (TANK),
    .X_INIT (496),
    .Y_INIT (368)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .dir_up     (dir_up),
    .dir_down   (dir_down),
    .dir_left   (dir_left),
    .dir_right  (dir_right),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out),
    .xpos_out   (xpos_out),
    .ypos_out   (ypos_out)
  );

  // 65 MHz is not needed for function; a 10-unit period keeps it simple.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one pixel position with blanking derived from the visible area.
  task automatic set_pixel(input int h, input int v);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    hblnk_in  = (h >= 1024);
    vblnk_in  = (v >= 768);
    hsync_in  = 1'($urandom_range(0, 1));
    vsync_in  = 1'($urandom_range(0, 1));
    rgb_in    = 12'($urandom_range(0, 4095));
  endtask

  // Reference compositing rule using the model position.
  function automatic logic [11:0] ref_rgb(input int h, input int v, input logic [11:0] bg);
    if (h >= 1024 || v >= 768) return 12'h000;
    if (h >= mx && h < mx + RW && v >= my && v < my + RH) return TANK;
    return bg;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_pixel($urandom_range(0, 1343), $urandom_range(0, 805));
      dir_up    = 1'($urandom_range(0, 1));
      dir_down  = 1'($urandom_range(0, 1));
      dir_left  = 1'($urandom_range(0, 1));
      dir_right = 1'($urandom_range(0, 1));
      step();
      tests++;
      if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== '0) begin
        fails++;
        $display("[TB] FAIL reset_outputs got h=%0d v=%0d rgb=%h expected all zero",
                 hcount_out, vcount_out, rgb_out);
      end
      tests++;
      if (xpos_out !== 11'd496 || ypos_out !== 10'd368) begin
        fails++;
        $display("[TB] FAIL reset_pos got (%0d,%0d) expected (496,368)", xpos_out, ypos_out);
      end
    end
    // Release with vblank already high: no edge, so no movement.
    set_pixel(100, 780);
    dir_right = 1'b1;
    dir_down  = 1'b1;
    dir_left  = 1'b0;
    dir_up    = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    tests++;
    if (xpos_out !== 11'd496 || ypos_out !== 10'd368) begin
      fails++;
      $display("[TB] FAIL no_edge_after_reset got (%0d,%0d) expected (496,368)", xpos_out, ypos_out);
    end
    dir_right = 1'b0;
    dir_down  = 1'b0;
  endtask

  // Timing bus delayed by two cycles and RGB composited from the model.
  task automatic test_alignment(input int n);
    int ph, pv, ch, cv, h, v;
    logic phs, pvs, chs, cvs;
    logic [11:0] prgb, crgb, exp;
    int fh[8];
    int fv[8];
    fh[0] = mx;          fv[0] = my;
    fh[1] = mx + RW - 1; fv[1] = my + RH - 1;
    fh[2] = mx + RW;     fv[2] = my;
    fh[3] = (mx > 0) ? mx - 1 : mx + RW + 1; fv[3] = my;
    fh[4] = mx;          fv[4] = my + RH;
    fh[5] = mx;          fv[5] = (my > 0) ? my - 1 : my + RH + 1;
    fh[6] = 1023;        fv[6] = 767;
    fh[7] = 1024;        fv[7] = my;
    dir_up = 0; dir_down = 0; dir_left = 0; dir_right = 0;
    ph = 0; pv = 0; phs = 0; pvs = 0; prgb = '0;
    ch = 0; cv = 0; chs = 0; cvs = 0; crgb = '0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        if (i < 8) begin
          h = fh[i]; v = fv[i];
        end else if ($urandom_range(0, 1) == 1) begin
          h = mx - 2 + int'($urandom_range(0, RW + 3));
          v = my - 2 + int'($urandom_range(0, RH + 3));
          if (h < 0) h = 0;
          if (v < 0) v = 0;
        end else begin
          h = $urandom_range(0, 1343);
          v = $urandom_range(0, 805);
        end
        set_pixel(h, v);
        ch = h; cv = v; chs = hsync_in; cvs = vsync_in; crgb = rgb_in;
      end
      step();
      if (i > 0) begin
        tests++;
        if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !==
            {11'(ph), 10'(pv), phs, pvs, (ph >= 1024), (pv >= 768)}) begin
          fails++;
          $display("[TB] FAIL align_timing got h=%0d v=%0d s=%b%b b=%b%b expected h=%0d v=%0d s=%b%b",
                   hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                   ph, pv, phs, pvs);
        end
        exp = ref_rgb(ph, pv, prgb);
        tests++;
        if (rgb_out !== exp) begin
          fails++;
          $display("[TB] FAIL align_rgb at h=%0d v=%0d got %h expected %h (tank at %0d,%0d)",
                   ph, pv, rgb_out, exp, mx, my);
        end
      end
      ph = ch; pv = cv; phs = chs; pvs = cvs; prgb = crgb;
    end
  endtask

  // One frame: active lines, then a vblank rising edge, checking position latency.
  task automatic run_frame(input logic l, input logic r, input logic u, input logic d,
                           input logic pre_down);
    int ox, oy, nx, ny;
    ox = mx; oy = my;
    dir_left = l; dir_right = r; dir_up = u; dir_down = pre_down;
    for (int i = 0; i < 3; i++) begin
      set_pixel($urandom_range(0, 1023), $urandom_range(0, 767));
      step();
    end
    dir_down = d;
    set_pixel($urandom_range(0, 1023), $urandom_range(0, 767));
    step();
    set_pixel($urandom_range(0, 1343), 768 + int'($urandom_range(0, 37)));
    step();
    tests++;
    if (xpos_out !== 11'(ox) || ypos_out !== 10'(oy)) begin
      fails++;
      $display("[TB] FAIL pos_at_tick got (%0d,%0d) expected (%0d,%0d)", xpos_out, ypos_out, ox, oy);
    end
    if (l && !r)      nx = (ox - MV < 0) ? 0 : ox - MV;
    else if (r && !l) nx = (ox + MV > 1024 - RW) ? 1024 - RW : ox + MV;
    else              nx = ox;
    if (u && !d)      ny = (oy - MV < 0) ? 0 : oy - MV;
    else if (d && !u) ny = (oy + MV > 768 - RH) ? 768 - RH : oy + MV;
    else              ny = oy;
    dir_left  = 1'($urandom_range(0, 1));
    dir_right = 1'($urandom_range(0, 1));
    dir_up    = 1'($urandom_range(0, 1));
    dir_down  = 1'($urandom_range(0, 1));
    step();
    tests++;
    if (xpos_out !== 11'(nx) || ypos_out !== 10'(oy)) begin
      fails++;
      $display("[TB] FAIL x_latency got (%0d,%0d) expected (%0d,%0d)", xpos_out, ypos_out, nx, oy);
    end
    step();
    tests++;
    if (xpos_out !== 11'(nx) || ypos_out !== 10'(ny)) begin
      fails++;
      $display("[TB] FAIL y_latency got (%0d,%0d) expected (%0d,%0d)", xpos_out, ypos_out, nx, ny);
    end
    step();
    step();
    mx = nx; my = ny;
  endtask

  task automatic test_movement();
    for (int i = 0; i < 3; i++) run_frame(0, 1, 0, 0, 0);
    tests++;
    if (xpos_out !== 11'd502) begin
      fails++;
      $display("[TB] FAIL move_right3 got %0d expected 502", xpos_out);
    end
    test_alignment(60);
  endtask

  task automatic test_conflict_sampling();
    int ox, oy;
    ox = mx; oy = my;
    run_frame(1, 1, 1, 1, 1);
    tests++;
    if (xpos_out !== 11'(ox) || ypos_out !== 10'(oy)) begin
      fails++;
      $display("[TB] FAIL conflict got (%0d,%0d) expected (%0d,%0d)", xpos_out, ypos_out, ox, oy);
    end
    run_frame(0, 0, 0, 0, 1);
    tests++;
    if (ypos_out !== 10'(oy)) begin
      fails++;
      $display("[TB] FAIL down_glitch got %0d expected %0d", ypos_out, oy);
    end
  endtask

  task automatic test_clamp();
    while (mx < 990) run_frame(0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) run_frame(0, 1, 0, 0, 0);
    tests++;
    if (xpos_out !== 11'd992) begin
      fails++;
      $display("[TB] FAIL clamp_right got %0d expected 992", xpos_out);
    end
    test_alignment(40);
    while (my > 0) run_frame(0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) run_frame(0, 0, 1, 0, 0);
    tests++;
    if (ypos_out !== 10'd0) begin
      fails++;
      $display("[TB] FAIL clamp_up got %0d expected 0", ypos_out);
    end
    while (mx > 0) run_frame(1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) run_frame(1, 0, 0, 0, 0);
    tests++;
    if (xpos_out !== 11'd0) begin
      fails++;
      $display("[TB] FAIL clamp_left got %0d expected 0", xpos_out);
    end
    test_alignment(40);
    while (my < 736) run_frame(0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) run_frame(0, 0, 0, 1, 0);
    tests++;
    if (ypos_out !== 10'd736) begin
      fails++;
      $display("[TB] FAIL clamp_down got %0d expected 736", ypos_out);
    end
    test_alignment(40);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    test_alignment(200);
  endtask

  task automatic test_async_reset();
    if (mx == 496 && my == 368) run_frame(0, 1, 0, 0, 0);
    dir_up = 0; dir_down = 0; dir_left = 0; dir_right = 0;
    for (int i = 0; i < 3; i++) begin
      set_pixel(500, 380);
      rgb_in = 12'hfff;
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== '0) begin
      fails++;
      $display("[TB] FAIL async_clear got h=%0d v=%0d rgb=%h expected all zero",
               hcount_out, vcount_out, rgb_out);
    end
    tests++;
    if (xpos_out !== 11'd496 || ypos_out !== 10'd368) begin
      fails++;
      $display("[TB] FAIL async_pos got (%0d,%0d) expected (496,368)", xpos_out, ypos_out);
    end
    step();
    step();
    rst_n = 1'b1;
    mx = 496; my = 368;
    test_alignment(60);
  endtask

  initial begin
    rst_n     = 1'b0;
    hcount_in = '0; vcount_in = '0;
    hsync_in  = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
    rgb_in    = '0;
    dir_up    = 0; dir_down = 0; dir_left = 0; dir_right = 0;
    test_reset();
    test_alignment(300);
    test_movement();
    test_conflict_sampling();
    test_clamp();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/draw_tank.md
# draw_tank

Pixel-pipeline stage directly downstream of the VGA timing generator. It takes the timing bus (hcount/vcount/syncs/blanks) plus background RGB and overlays a solid player-tank rectangle. The rectangle's position is updated once per frame from four direction inputs, with clamping to the visible 1024x768 area. It re-emits the timing bus delayed to stay aligned with its RGB output, so further draw stages can be chained.

## Interface
- RECT_W, 32: rectangle width in pixels (1..1024)
- RECT_H, 32: rectangle height in pixels (1..768)
- STEP, 2: pixels moved per frame per active axis (1..RECT_W)
- COLOR, 12'h080: rectangle RGB444
- X_INIT, 496: reset x of top-left corner
- Y_INIT, 368: reset y of top-left corner
- clk  in  1  pixel clock (65 MHz)
- rst_n  in  1  asynchronous, active-low reset
- hcount_in  in  11  horizontal pixel counter
- vcount_in  in  10  vertical line counter
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing strobes, active high
- rgb_in  in  12  background pixel
- dir_up, dir_down, dir_left, dir_right  in  1 each  level-sensitive movement requests, synchronous to clk
- hcount_out  out  11  hcount_in delayed 2 cycles
- vcount_out  out  10  vcount_in delayed 2 cycles
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  inputs delayed 2 cycles
- rgb_out  out  12  composited pixel
- xpos_out  out  11  current top-left x
- ypos_out  out  10  current top-left y

## Operation
- Frame tick: one-cycle pulse when vblnk_in = 1 and its registered copy = 0 (rising edge). The movement FSM acts only on this tick, so the position never changes during active video.
- Movement FSM states: WAIT_FRAME -> (tick) STEP_X -> STEP_Y -> WAIT_FRAME. Each of STEP_X and STEP_Y lasts one cycle. No tick means the FSM stays in WAIT_FRAME.
- Direction inputs are sampled into registers on the tick cycle. Changes after the tick are ignored until the next frame.
- STEP_X:
  - left only: x = max(x - STEP, 0)
  - right only: x = min(x + STEP, 1024 - RECT_W)
  - both or neither: x unchanged
- STEP_Y: same rules with up (decrease), down (increase), and bound 768 - RECT_H.
- Arithmetic uses one extra bit (12-bit x, 11-bit y) so that subtract-below-zero and add-past-limit are detected without wrap. The stored position is always in range.
- Hit test (stage 1): hit = !hblnk_in & !vblnk_in & hcount_in ∈ [x, x+RECT_W) & vcount_in ∈ [y, y+RECT_H). Bounds are computed at extended width.
- Stage 2 RGB select:
  - blanking (delayed hblnk or vblnk) -> rgb_out = 12'h000
  - else hit -> COLOR
  - else delayed rgb_in
- A tick arriving while the FSM is not in WAIT_FRAME cannot happen (frame period ≫ 3 cycles). If it does, it is ignored.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Pixel latency is exactly 2 cycles. hcount/vcount/sync/blank/rgb outputs are mutually aligned.
- Position latency: xpos_out valid 2 cycles after the tick; ypos_out valid 3 cycles after the tick.
- The new position takes effect on the first active line after vblank.
- Reset (asynchronous assert, synchronous deassert handled upstream) sets:
  - all timing outputs and rgb_out to 0
  - pipeline registers to 0
  - xpos_out = X_INIT, ypos_out = Y_INIT
  - FSM = WAIT_FRAME, vblnk edge register = 0
- Reset asserted mid-frame or mid-STEP clears immediately. Any partial update is discarded.
- After release, the first tick requires a fresh 0->1 edge of vblnk_in.

## Structure
- Shared package vga_pkg holds:
  - H_ACTIVE = 1024, V_ACTIVE = 768
  - HCNT_W = 11, VCNT_W = 10, RGB_W = 12
  - colour constants
  - the movement state enum (WAIT_FRAME, STEP_X, STEP_Y)
- Sub-module tank_move_fsm contains the tick detector, direction sample registers, FSM, and clamped position registers.
- draw_tank top holds the two-stage pixel pipeline and instantiates tank_move_fsm.

## Test plan
- Reset: hold rst_n = 0 for 5 cycles with random inputs -> all outputs 0, xpos_out = 496, ypos_out = 368. Release; no movement without a vblnk edge.
- Alignment: drive counters 0..1343 and 0..805 with no directions -> every *_out equals its input 2 cycles earlier. rgb_out = 12'h080 exactly at h 496..527, v 368..399; rgb_in elsewhere in active video; 0 in blanking.
- Movement: dir_right = 1 for 3 frames -> xpos_out 496 -> 498 -> 500 -> 502, updating 2 cycles after each vblnk rising edge. Pixel output is unchanged until the next active line.
- Clamp: start x = 990, dir_right held -> x goes 992 then stays at 992. Start y = 1, dir_up -> y = 0, then stays 0.
- Conflict and sampling: dir_left = dir_right = 1 -> x unchanged. dir_down toggled high only mid-frame and low before the tick -> y unchanged.
- Async reset mid-frame: assert rst_n = 0 at h = 500, v = 380 with the rectangle displaced -> outputs clear in the same cycle without a clock edge. Position returns to (496, 368).
